// File: rtl/pipelined_rca_addsub.sv
// Segmented ripple-carry adder/subtractor: one SEG_W-bit ripple segment per stage, carry registered
// between stages, global valid/ready stall. Define PIPE_ADDSUB_OVF_EN to add the signed-overflow output ovf.

module rca_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module pipelined_rca_addsub #(
    parameter int WIDTH = 128,
    parameter int SEG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDSUB_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);
    localparam int NSEG = WIDTH / SEG_W;

    genvar gi;
    genvar gj;

    if (SEG_W < 1 || NSEG < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $error("pipelined_rca_addsub: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             advance;
    logic [WIDTH-1:0] b_prep;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    // Subtract is A + ~B + 1; cin only matters in add mode.
    assign b_prep   = sub ? ~b : b;
    assign c0       = sub | cin;

    for (gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int LO_W = gi * SEG_W;
        localparam int HI_W = (NSEG - 1 - gi) * SEG_W;

        logic [SEG_W-1:0]      seg_a;
        logic [SEG_W-1:0]      seg_b;
        logic [SEG_W-1:0]      seg_s;
        logic [SEG_W:0]        chain;
        logic                  v_in;
        logic [LO_W+SEG_W-1:0] s_next;
        logic [LO_W+SEG_W-1:0] s_reg;
        logic                  c_reg;
        logic                  v_reg;

        if (gi == 0) begin : g_head
            assign seg_a    = a[SEG_W-1:0];
            assign seg_b    = b_prep[SEG_W-1:0];
            assign chain[0] = c0;
            assign v_in     = in_valid;
            assign s_next   = seg_s;
        end else begin : g_body
            // Operand segment comes from the previous stage's forwarded upper bits.
            assign seg_a    = g_stage[gi-1].g_fwd.a_hi_reg[SEG_W-1:0];
            assign seg_b    = g_stage[gi-1].g_fwd.b_hi_reg[SEG_W-1:0];
            assign chain[0] = g_stage[gi-1].c_reg;
            assign v_in     = g_stage[gi-1].v_reg;
            assign s_next   = {seg_s, g_stage[gi-1].s_reg};
        end

        for (gj = 0; gj < SEG_W; gj++) begin : g_bit
            rca_full_adder u_fa (
                .x  (seg_a[gj]),
                .y  (seg_b[gj]),
                .ci (chain[gj]),
                .s  (seg_s[gj]),
                .co (chain[gj+1])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg <= 1'b0;
                c_reg <= 1'b0;
                s_reg <= '0;
            end else if (advance) begin
                v_reg <= v_in;
                c_reg <= chain[SEG_W];
                s_reg <= s_next;
            end
        end

        // Upper operand segments not yet summed travel down the pipe alongside the beat.
        if (HI_W > 0) begin : g_fwd
            logic [HI_W-1:0] a_hi_next;
            logic [HI_W-1:0] b_hi_next;
            logic [HI_W-1:0] a_hi_reg;
            logic [HI_W-1:0] b_hi_reg;

            if (gi == 0) begin : g_src_in
                assign a_hi_next = a[WIDTH-1:SEG_W];
                assign b_hi_next = b_prep[WIDTH-1:SEG_W];
            end else begin : g_src_prev
                assign a_hi_next = g_stage[gi-1].g_fwd.a_hi_reg[HI_W+SEG_W-1:SEG_W];
                assign b_hi_next = g_stage[gi-1].g_fwd.b_hi_reg[HI_W+SEG_W-1:SEG_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_reg <= '0;
                    b_hi_reg <= '0;
                end else if (advance) begin
                    a_hi_reg <= a_hi_next;
                    b_hi_reg <= b_hi_next;
                end
            end
        end

`ifdef PIPE_ADDSUB_OVF_EN
        if (gi == NSEG - 1) begin : g_ovf
            logic ovf_reg;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (advance) begin
                    ovf_reg <= chain[SEG_W-1] ^ chain[SEG_W];
                end
            end
        end
`endif
    end

    assign sum       = g_stage[NSEG-1].s_reg;
    assign cout      = g_stage[NSEG-1].c_reg;
    assign out_valid = g_stage[NSEG-1].v_reg;
`ifdef PIPE_ADDSUB_OVF_EN
    assign ovf       = g_stage[NSEG-1].g_ovf.ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Bench for pipelined_rca_addsub (default 128/32 build; ovf checks active when PIPE_ADDSUB_OVF_EN is defined).
`timescale 1ns/1ps
module tb_pipelined_rca_addsub;
    localparam int W  = 128;
    localparam int SW = 32;
    localparam int NS = W / SW;

    typedef logic [W:0] wv_t;
    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_ADDSUB_OVF_EN
    logic         ovf;
`endif

    pipelined_rca_addsub #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPE_ADDSUB_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input wv_t act, input wv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Plain wide arithmetic: A + B + cin, or A - B as A + ~B + 1.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic [W:0]   cc;
        exp_t         e;
        bb    = ts ? ~tb_ : tb_;
        cc    = '0;
        cc[0] = ts | tc;
        full  = {1'b0, ta} + {1'b0, bb} + cc;
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.v   = (ta[W-1] == bb[W-1]) && (e.s[W-1] != ta[W-1]);
        return e;
    endfunction

    exp_t         q[$];
    int           out_cyc[$];
    exp_t         e_cmp;
    logic         stall_prev = 1'b0;
    logic [W-1:0] sum_prev;
    logic         cout_prev;
    int           stall_cnt = 0;
    int           ready_low_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", wv_t'(out_valid), wv_t'(1));
                check("stall_hold_sum", wv_t'(sum), wv_t'(sum_prev));
                check("stall_hold_cout", wv_t'(cout), wv_t'(cout_prev));
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check("in_ready_stall", wv_t'(in_ready), wv_t'(0));
            end
            if (!in_ready) ready_low_cnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", wv_t'(out_valid), wv_t'(0));
                end else begin
                    e_cmp = q.pop_front();
                    check("model_sum", wv_t'(sum), wv_t'(e_cmp.s));
                    check("model_cout", wv_t'(cout), wv_t'(e_cmp.c));
`ifdef PIPE_ADDSUB_OVF_EN
                    check("model_ovf", wv_t'(ovf), wv_t'(e_cmp.v));
`endif
                    out_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            stall_prev = out_valid && !out_ready;
            sum_prev   = sum;
            cout_prev  = cout;
        end
    end

    task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                              input logic ts, output int acc_cyc);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc     = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("accept_timeout", wv_t'(in_ready), wv_t'(1));
        in_valid = 1'b0;
        // Changing sub/cin after acceptance must not affect the beat.
        sub = ~ts; cin = ~tc;
    endtask

    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts,
                           input logic [W-1:0] esum, input logic ecout, input logic eovf, input string nm);
        int acc_cyc;
        int guard;
        drive_beat(ta, tb_, tc, ts, acc_cyc);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({nm, "_latency"}, wv_t'(cyc - acc_cyc), wv_t'(NS));
        check({nm, "_sum"}, wv_t'(sum), wv_t'(esum));
        check({nm, "_cout"}, wv_t'(cout), wv_t'(ecout));
`ifdef PIPE_ADDSUB_OVF_EN
        check({nm, "_ovf"}, wv_t'(ovf), wv_t'(eovf));
`else
        if (eovf === 1'bx) $display("unused");
`endif
        $display("txn %s: a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b", nm, ta, tb_, tc, ts, sum, cout);
        @(posedge clk);
        #1;
    endtask

    task automatic stream8(input int variant);
        int acc_cyc;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ta;
            logic [W-1:0] tb_;
            ta  = {4{32'hFFFF_FFF0 + 32'(i) + 32'(variant)}};
            tb_ = {4{32'h0000_0010 * 32'(i + 1)}};
            drive_beat(ta, tb_, i[1], i[0], acc_cyc);
            $display("txn stream%0d beat %0d accepted in cycle %0d", variant, i, acc_cyc);
        end
    endtask

    exp_t pin;
    int   acc_tmp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", wv_t'(out_valid), wv_t'(0));
        check("reset_sum", wv_t'(sum), wv_t'(0));
        check("reset_cout", wv_t'(cout), wv_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pin = model(128'd5, 128'd7, 1'b1, 1'b1);
        check("pin_model_sub_sum", wv_t'(pin.s), wv_t'({W{1'b1}} - 128'd1));
        check("pin_model_sub_cout", wv_t'(pin.c), wv_t'(0));
        pin = model({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
        check("pin_model_ovf", wv_t'(pin.v), wv_t'(1));

        run_one({W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0, "max_plus_one");
        run_one(128'd5, 128'd7, 1'b1, 1'b1, {W{1'b1}} - 128'd1, 1'b0, 1'b0, "sub_borrow");
        run_one(128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0, "sub_pos");
        run_one(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, "seg_chain");
        run_one(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd0, 1'b1, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0, "cin_add");
        run_one({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, "ovf_add");
        run_one({1'b1, {(W-1){1'b0}}}, 128'd1, 1'b0, 1'b1, {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1, "ovf_sub");

        out_cyc.delete();
        stream8(0);
        repeat (NS + 3) @(posedge clk);
        #1;
        check("stream_count", wv_t'(out_cyc.size()), wv_t'(8));
        for (int i = 1; i < out_cyc.size(); i++)
            check("stream_gapless", wv_t'(out_cyc[i]), wv_t'(out_cyc[0] + i));
        check("stream_drained", wv_t'(q.size()), wv_t'(0));

        out_cyc.delete();
        stall_cnt = 0;
        ready_low_cnt = 0;
        fork
            stream8(1);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (NS + 3) @(posedge clk);
        #1;
        check("stall_stream_count", wv_t'(out_cyc.size()), wv_t'(8));
        check("stall_cycles", wv_t'(stall_cnt), wv_t'(3));
        check("stall_in_ready_low", wv_t'(ready_low_cnt), wv_t'(3));
        check("stall_drained", wv_t'(q.size()), wv_t'(0));

        for (int i = 0; i < 3; i++)
            drive_beat({4{32'h1234_5678}}, {4{32'h0F0F_0F0F}} + 128'(i), 1'b0, 1'b0, acc_tmp);
        out_cyc.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", wv_t'(out_valid), wv_t'(0));
        check("midreset_sum", wv_t'(sum), wv_t'(0));
        check("midreset_cout", wv_t'(cout), wv_t'(0));
        $display("txn mid_reset: asserted in cycle %0d", cyc);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_stale", wv_t'(out_cyc.size()), wv_t'(0));
        run_one(128'd100, 128'd23, 1'b0, 1'b0, 128'd123, 1'b0, 1'b0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
